// File: rtl/bw_signed_divider.sv
// Sequential signed divider: 2N-bit dividend by N-bit divisor via unsigned restoring
// division on magnitudes, followed by a single sign/flag fix-up cycle.
module bw_signed_divider #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           ovf,
    output logic           dbz
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, and out_valid stays high with stable outputs until out_ready.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              CW        = $clog2(2 * N) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(2 * N - 1);

    logic [1:0]     state_q, state_d;
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   dvd_lo_q, dvd_lo_d;
    logic           dvd_neg_q, dvd_neg_d;
    logic           dvs_neg_q, dvs_neg_d;
    logic           zero_q, zero_d;
    logic [N:0]     rem_q, rem_d;
    logic [2*N-1:0] quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           ovf_q, ovf_d;
    logic           dbz_q, dbz_d;
    logic           out_valid_q, out_valid_d;

    logic [N:0]     r_shift;
    logic [N:0]     trial;
    logic [2*N:0]   q_fix;
    logic [N-1:0]   r_fix;
    logic           q_fits;

    always_comb begin
        r_shift = {rem_q[N-1:0], dvd_q[2*N-1]};
        trial   = r_shift - {1'b0, dvs_q};
        // One extra bit keeps +2^(2N-1) (e.g. -128 / -1) distinguishable from its negation.
        q_fix   = (dvd_neg_q ^ dvs_neg_q) ? -{1'b0, quo_q} : {1'b0, quo_q};
        r_fix   = dvd_neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
        q_fits  = (&q_fix[2*N:N-1]) | ~(|q_fix[2*N:N-1]);

        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        dvd_lo_d    = dvd_lo_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        zero_d      = zero_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_d     = dividend[2*N-1] ? -dividend : dividend;
                    dvs_d     = divisor[N-1] ? -divisor : divisor;
                    dvd_lo_d  = dividend[N-1:0];
                    dvd_neg_d = dividend[2*N-1];
                    dvs_neg_d = divisor[N-1];
                    zero_d    = (divisor == '0);
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                dvd_d = {dvd_q[2*N-2:0], 1'b0};
                if (!trial[N]) begin
                    rem_d = trial;
                    quo_d = {quo_q[2*N-2:0], 1'b1};
                end else begin
                    rem_d = r_shift;
                    quo_d = {quo_q[2*N-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            S_FIX: begin
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_lo_q;
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = q_fix[N-1:0];
                    remainder_d = r_fix;
                    ovf_d       = ~q_fits;
                    dbz_d       = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dvd_lo_q    <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            zero_q      <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            dvd_lo_q    <= dvd_lo_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            zero_q      <= zero_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_bw_signed_divider.sv
// Directed-vector bench for bw_signed_divider (N=4): table of hand-computed results,
// backpressure and mid-operation reset sequences, then random and multiply round-trip checks.
module tb_bw_signed_divider;
    localparam int N = 4;
    localparam int EXP_LAT = 2 * N + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   dividend = '0;
    logic [3:0]   divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [3:0]   quotient;
    logic [3:0]   remainder;
    logic         ovf;
    logic         dbz;

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       ovf;
        logic       dbz;
    } vec_t;

    vec_t vecs[15];

    bw_signed_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        // Scramble operands after the accepting edge; the result must not change.
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [3:0] q, input logic [3:0] r,
                             input logic e_ovf, input logic e_dbz, input int lat);
        chk($sformatf("%s.quotient", tag), {28'd0, quotient}, {28'd0, q});
        chk($sformatf("%s.remainder", tag), {28'd0, remainder}, {28'd0, r});
        chk($sformatf("%s.ovf", tag), {31'd0, ovf}, {31'd0, e_ovf});
        chk($sformatf("%s.dbz", tag), {31'd0, dbz}, {31'd0, e_dbz});
        chk($sformatf("%s.latency", tag), lat, EXP_LAT);
    endtask

    task automatic model(input logic [7:0] a, input logic [3:0] b, output logic [9:0] e);
        int ai;
        int bi;
        int qi;
        int ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            e = {4'hF, a[3:0], 1'b0, 1'b1};
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            e = {qi[3:0], ri[3:0], (qi > 7 || qi < -8), 1'b0};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [9:0] e;
        logic [7:0] a;
        logic [3:0] b;
        logic [3:0] ra;

        vecs[0]  = '{8'd214, 4'd5,  4'b1000, 4'b1110, 1'b0, 1'b0}; // -42 / 5
        vecs[1]  = '{8'd49,  4'd8,  4'b1010, 4'b0001, 1'b0, 1'b0}; // 49 / -8
        vecs[2]  = '{8'd42,  4'd11, 4'b1000, 4'b0010, 1'b0, 1'b0}; // 42 / -5
        vecs[3]  = '{8'd63,  4'd7,  4'b1001, 4'b0000, 1'b1, 1'b0}; // 63 / 7
        vecs[4]  = '{8'd128, 4'd15, 4'b0000, 4'b0000, 1'b1, 1'b0}; // -128 / -1
        vecs[5]  = '{8'd20,  4'd0,  4'b1111, 4'b0100, 1'b0, 1'b1}; // 20 / 0
        vecs[6]  = '{8'd7,   4'd2,  4'b0011, 4'b0001, 1'b0, 1'b0}; // 7 / 2
        vecs[7]  = '{8'd249, 4'd2,  4'b1101, 4'b1111, 1'b0, 1'b0}; // -7 / 2
        vecs[8]  = '{8'd249, 4'd14, 4'b0011, 4'b1111, 1'b0, 1'b0}; // -7 / -2
        vecs[9]  = '{8'd0,   4'd3,  4'b0000, 4'b0000, 1'b0, 1'b0}; // 0 / 3
        vecs[10] = '{8'd128, 4'd8,  4'b0000, 4'b0000, 1'b1, 1'b0}; // -128 / -8 = 16
        vecs[11] = '{8'd127, 4'd8,  4'b0001, 4'b0111, 1'b1, 1'b0}; // 127 / -8 = -15 r 7
        vecs[12] = '{8'd255, 4'd0,  4'b1111, 4'b1111, 1'b0, 1'b1}; // -1 / 0
        vecs[13] = '{8'd248, 4'd1,  4'b1000, 4'b0000, 1'b0, 1'b0}; // -8 / 1
        vecs[14] = '{8'd128, 4'd1,  4'b0000, 4'b0000, 1'b1, 1'b0}; // -128 / 1

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset.quotient", {28'd0, quotient}, 32'd0);
        chk("reset.remainder", {28'd0, remainder}, 32'd0);
        chk("reset.flags", {30'd0, ovf, dbz}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            n_vec++;
            start_op(vecs[i].a, vecs[i].b);
            wait_result(lat);
            check_res($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].ovf, vecs[i].dbz, lat);
            finish_op();
        end

        // Backpressure: result must hold for 5 cycles with in_ready low.
        n_vec++;
        start_op(8'd63, 4'd7);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
            check_res("bp", 4'b1001, 4'b0000, 1'b1, 1'b0, lat);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp.idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp.idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp.idle_quotient_hold", {28'd0, quotient}, 32'h9);

        // Reset during CALC aborts the operation.
        n_vec++;
        start_op(8'd214, 4'd5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.quotient", {28'd0, quotient}, 32'd0);
        chk("rst.remainder", {28'd0, remainder}, 32'd0);
        chk("rst.flags", {30'd0, ovf, dbz}, 32'd0);
        repeat (12) begin
            @(negedge clk);
            chk("rst.no_result", {31'd0, out_valid}, 32'd0);
        end
        n_vec++;
        start_op(8'd214, 4'd5);
        wait_result(lat);
        check_res("after_rst", 4'b1000, 4'b1110, 1'b0, 1'b0, lat);
        finish_op();

        // Random operand pairs against an integer reference.
        for (int i = 0; i < 400; i++) begin
            n_vec++;
            a = 8'($urandom);
            b = 4'($urandom_range(0, 15));
            model(a, b, e);
            exp_q.push_back(e);
            start_op(a, b);
            wait_result(lat);
            e = exp_q.pop_front();
            chk($sformatf("rand a=%0d b=%0d .result", $signed(a), $signed(b)),
                {22'd0, quotient, remainder, ovf, dbz}, {22'd0, e});
            chk("rand.latency", lat, EXP_LAT);
            finish_op();
        end

        // Round trip: (x * y) / y == x with zero remainder.
        for (int i = 0; i < 200; i++) begin
            n_vec++;
            ra = 4'($urandom);
            b  = 4'($urandom_range(1, 15));
            a  = 8'($signed(ra) * $signed(b));
            start_op(a, b);
            wait_result(lat);
            chk($sformatf("trip x=%0d y=%0d .result", $signed(ra), $signed(b)),
                {22'd0, quotient, remainder, ovf, dbz}, {22'd0, ra, 4'd0, 2'b00});
            finish_op();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
